// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, FSM state encoding and defaults for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned RS1_WIDTH      = 5;
  localparam int unsigned RS2_WIDTH      = 5;
  localparam int unsigned RD_WIDTH       = 5;
  localparam int unsigned STALL_W        = 16;
  localparam int unsigned MC_TIMEOUT_DEF = 64;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  // A source operand collides with a destination when it is actually read and names it.
  function automatic logic src_hits_rd(input logic [RD_WIDTH-1:0] rs,
                                       input logic                used,
                                       input logic [RD_WIDTH-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID/EX hazard inputs and pipeline hold/flush controls exchanged with pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [RS1_WIDTH-1:0] rs1_id;
  logic [RS2_WIDTH-1:0] rs2_id;
  logic                 rs1_used_id;
  logic                 rs2_used_id;
  logic [RD_WIDTH-1:0]  rd_ex;
  logic                 mem_read_ex;
  logic                 mc_op_ex;
  logic                 branch_taken_ex;
  logic                 mc_done;

  logic                 pc_hold;
  logic                 if_id_hold;
  logic                 id_ex_hold;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 mc_start;
  logic                 mc_err;
  logic [STALL_W-1:0]   stall_cycles;

  // Pipeline side
  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex,
           mem_read_ex, mc_op_ex, branch_taken_ex, mc_done,
    input  pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_bubble,
           mc_start, mc_err, stall_cycles
  );

  // Controller side
  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex,
           mem_read_ex, mc_op_ex, branch_taken_ex, mc_done,
    output pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_bubble,
           mc_start, mc_err, stall_cycles
  );

endinterface

// File: rtl/hazard_detect.sv
// Purely combinational load-use detector between the ID instruction and a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [RS1_WIDTH-1:0] rs1_id_i,
  input  logic [RS2_WIDTH-1:0] rs2_id_i,
  input  logic                 rs1_used_id_i,
  input  logic                 rs2_used_id_i,
  input  logic [RD_WIDTH-1:0]  rd_ex_i,
  input  logic                 mem_read_ex_i,
  output logic                 load_use_c_o
);

  logic rs1_hit_c;
  logic rs2_hit_c;

  assign rs1_hit_c = src_hits_rd(RD_WIDTH'(rs1_id_i), rs1_used_id_i, rd_ex_i);
  assign rs2_hit_c = src_hits_rd(RD_WIDTH'(rs2_id_i), rs2_used_id_i, rd_ex_i);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use_c_o = mem_read_ex_i && (rd_ex_i != '0) && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: branch flush, load-use stall and multi-cycle unit wait with timeout.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  ctrl_if
);

  localparam int unsigned       TMR_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               err_q, err_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic load_use_c;
  logic pc_hold_c, if_id_hold_c, id_ex_hold_c;
  logic if_id_flush_c, id_ex_bubble_c, mc_start_c;

  hazard_detect u_hazard_detect (
    .rs1_id_i      (ctrl_if.rs1_id),
    .rs2_id_i      (ctrl_if.rs2_id),
    .rs1_used_id_i (ctrl_if.rs1_used_id),
    .rs2_used_id_i (ctrl_if.rs2_used_id),
    .rd_ex_i       (ctrl_if.rd_ex),
    .mem_read_ex_i (ctrl_if.mem_read_ex),
    .load_use_c_o  (load_use_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    err_d           = err_q;
    pc_hold_c       = 1'b0;
    if_id_hold_c    = 1'b0;
    id_ex_hold_c    = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    mc_start_c      = 1'b0;

    case (state_q)
      RUN: begin
        // Branch redirect wins: the younger instructions are squashed anyway.
        if (ctrl_if.branch_taken_ex) begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (ctrl_if.mc_op_ex) begin
          mc_start_c   = 1'b1;
          pc_hold_c    = 1'b1;
          if_id_hold_c = 1'b1;
          id_ex_hold_c = 1'b1;
          tmr_d        = '0;
          state_d      = MC_WAIT;
        end else if (load_use_c) begin
          pc_hold_c      = 1'b1;
          if_id_hold_c   = 1'b1;
          id_ex_bubble_c = 1'b1;
        end
      end
      MC_WAIT: begin
        if (ctrl_if.mc_done) begin
          state_d = RUN;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          pc_hold_c    = 1'b1;
          if_id_hold_c = 1'b1;
          id_ex_hold_c = 1'b1;
          tmr_d        = tmr_q + TMR_W'(1);
        end
      end
    endcase

    stall_d = (pc_hold_c && (stall_q != '1)) ? stall_q + STALL_W'(1) : stall_q;
  end

  // Controls are combinational and forced low during reset regardless of inputs.
  assign ctrl_if.pc_hold      = rst_n & pc_hold_c;
  assign ctrl_if.if_id_hold   = rst_n & if_id_hold_c;
  assign ctrl_if.id_ex_hold   = rst_n & id_ex_hold_c;
  assign ctrl_if.if_id_flush  = rst_n & if_id_flush_c;
  assign ctrl_if.id_ex_bubble = rst_n & id_ex_bubble_c;
  assign ctrl_if.mc_start     = rst_n & mc_start_c;
  assign ctrl_if.mc_err       = err_q;
  assign ctrl_if.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal pins plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MC_TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit m_busy   = 1'b0;
  bit m_err    = 1'b0;
  int m_waited = 0;
  int m_stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model; inputs are stable from posedge+1 until the next posedge.
  always @(negedge clk) begin
    bit e_ph, e_ih, e_eh, e_fl, e_bb, e_st, lu;
    e_ph = 0; e_ih = 0; e_eh = 0; e_fl = 0; e_bb = 0; e_st = 0;
    lu = bus.mem_read_ex && (bus.rd_ex != 0) &&
         ((bus.rs1_used_id && bus.rs1_id == bus.rd_ex) ||
          (bus.rs2_used_id && bus.rs2_id == bus.rd_ex));
    if (!rst_n) begin
      m_busy = 0; m_err = 0; m_waited = 0; m_stalls = 0;
    end else if (m_busy) begin
      if (!bus.mc_done && m_waited < int'(TIMEOUT) - 1) begin
        e_ph = 1; e_ih = 1; e_eh = 1;
      end
    end else if (bus.branch_taken_ex) begin
      e_fl = 1; e_bb = 1;
    end else if (bus.mc_op_ex) begin
      e_st = 1; e_ph = 1; e_ih = 1; e_eh = 1;
    end else if (lu) begin
      e_ph = 1; e_ih = 1; e_bb = 1;
    end

    chk("pc_hold",      32'(bus.pc_hold),      32'(e_ph));
    chk("if_id_hold",   32'(bus.if_id_hold),   32'(e_ih));
    chk("id_ex_hold",   32'(bus.id_ex_hold),   32'(e_eh));
    chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_fl));
    chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bb));
    chk("mc_start",     32'(bus.mc_start),     32'(e_st));
    chk("mc_err",       32'(bus.mc_err),       32'(m_err));
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));

    if (rst_n) begin
      if (m_busy) begin
        if (bus.mc_done) m_busy = 0;
        else if (m_waited == int'(TIMEOUT) - 1) begin m_err = 1; m_busy = 0; end
        else m_waited++;
      end else if (!bus.branch_taken_ex && bus.mc_op_ex) begin
        m_busy = 1; m_waited = 0;
      end
      if (e_ph && m_stalls < 65535) m_stalls++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1_id = '0; bus.rs2_id = '0; bus.rs1_used_id = 0; bus.rs2_used_id = 0;
    bus.rd_ex = '0; bus.mem_read_ex = 0; bus.mc_op_ex = 0;
    bus.branch_taken_ex = 0; bus.mc_done = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    idle();
    bus.mem_read_ex = 1; bus.rd_ex = rd; bus.rs1_id = rd; bus.rs1_used_id = 1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 0;
    idle();
    cyc();
    rst_n = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int holds;
    int waits;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rst_err",   32'(bus.mc_err),       32'd0);

    // Load-use on x5: one stall cycle
    cyc(); load_use(5'd5);
    @(negedge clk);
    chk("lu_pc_hold", 32'(bus.pc_hold),      32'd1);
    chk("lu_if_hold", 32'(bus.if_id_hold),   32'd1);
    chk("lu_bubble",  32'(bus.id_ex_bubble), 32'd1);
    cyc(); idle();
    @(negedge clk);
    chk("lu_release", 32'(bus.pc_hold),      32'd0);
    chk("lu_stall",   32'(bus.stall_cycles), 32'd1);

    // x0 exemption
    cyc(); load_use(5'd0);
    @(negedge clk);
    chk("x0_hold",   32'(bus.pc_hold),      32'd0);
    chk("x0_bubble", 32'(bus.id_ex_bubble), 32'd0);

    // Branch beats load-use
    cyc(); load_use(5'd3); bus.branch_taken_ex = 1;
    @(negedge clk);
    chk("br_flush",  32'(bus.if_id_flush),  32'd1);
    chk("br_bubble", 32'(bus.id_ex_bubble), 32'd1);
    chk("br_hold",   32'(bus.pc_hold),      32'd0);
    cyc(); idle();

    // Multi-cycle op completing on the 5th wait cycle
    do_reset();
    cyc(); bus.mc_op_ex = 1;
    @(negedge clk);
    chk("mc_start", 32'(bus.mc_start), 32'd1);
    holds = int'(bus.pc_hold);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("mc_start_once", 32'(bus.mc_start), 32'd0);
      holds += int'(bus.pc_hold);
    end
    cyc(); bus.mc_done = 1; bus.mc_op_ex = 0;
    @(negedge clk);
    holds += int'(bus.pc_hold);
    cyc(); bus.mc_done = 0;
    @(negedge clk);
    chk("mc_hold_cycles", 32'(holds),              32'd5);
    chk("mc_stall",       32'(bus.stall_cycles),   32'd5);
    chk("mc_back_run",    32'(bus.id_ex_hold),     32'd0);

    // Timeout with no completion
    do_reset();
    cyc(); bus.mc_op_ex = 1;
    @(negedge clk);
    chk("to_start", 32'(bus.mc_start), 32'd1);
    cyc(); bus.mc_op_ex = 0;
    waits = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      waits++;
      if (bus.pc_hold == 1'b0) break;
      cyc();
    end
    chk("to_wait_cycles", 32'(waits), 32'd64);
    cyc();
    @(negedge clk);
    chk("to_err", 32'(bus.mc_err), 32'd1);
    for (int k = 0; k < 10; k++) begin
      cyc(); bus.mc_done = k[0];
    end
    @(negedge clk);
    chk("to_err_sticky", 32'(bus.mc_err),       32'd1);
    chk("to_stall",      32'(bus.stall_cycles), 32'd64);
    cyc(); idle();

    // Reset on the 2nd wait cycle
    do_reset();
    cyc(); bus.mc_op_ex = 1;
    cyc(); bus.mc_op_ex = 0;
    cyc(); rst_n = 0; bus.branch_taken_ex = 1;
    #1;
    chk("rw_pc_hold", 32'(bus.pc_hold),      32'd0);
    chk("rw_id_ex",   32'(bus.id_ex_hold),   32'd0);
    chk("rw_flush",   32'(bus.if_id_flush),  32'd0);
    chk("rw_bubble",  32'(bus.id_ex_bubble), 32'd0);
    chk("rw_stall",   32'(bus.stall_cycles), 32'd0);
    cyc(); bus.branch_taken_ex = 0; rst_n = 1;
    cyc(); load_use(5'd7);
    @(negedge clk);
    chk("rw_run_lu",    32'(bus.pc_hold),    32'd1);
    chk("rw_run_noexh", 32'(bus.id_ex_hold), 32'd0);
    cyc(); idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n = ($urandom_range(0, 499) != 0);
      bus.rd_ex           = 5'($urandom_range(0, 7));
      bus.rs1_id          = 5'($urandom_range(0, 7));
      bus.rs2_id          = 5'($urandom_range(0, 7));
      bus.rs1_used_id     = 1'($urandom);
      bus.rs2_used_id     = 1'($urandom);
      bus.branch_taken_ex = ($urandom_range(0, 7) == 0);
      bus.mem_read_ex     = ($urandom_range(0, 2) == 0);
      bus.mc_op_ex        = !bus.mem_read_ex && ($urandom_range(0, 9) == 0);
      bus.mc_done         = (i < 1500) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 99) == 0);
    end
    cyc(); rst_n = 1; idle();

    // Stall counter saturation
    do_reset();
    cyc(); load_use(5'd9);
    repeat (65540) cyc();
    @(negedge clk);
    chk("sat_stall", 32'(bus.stall_cycles), 32'hFFFF);
    cyc(); idle();
    repeat (3) cyc();
    @(negedge clk);
    chk("sat_hold", 32'(bus.stall_cycles), 32'hFFFF);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
